muldiv_sequencer: RTL and testbench

//  Multi-cycle controller for the RV32M ops (MUL/MULH/MULHU/MULHSU/DIV/DIVU/REM/REMU) in the EX stage.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_if.sv | 24 ++
 rtl/div_iter_core.sv | 44 ++++
 rtl/muldiv_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM encodings and decode helpers for the RV32M multiply/divide sequencer.
// Only opcodes 01000..01111 reach this block; everything else stays in the single-cycle ALU.
package muldiv_pkg;

  localparam logic [4:0] OP_MUL    = 5'b01000;
  localparam logic [4:0] OP_MULH   = 5'b01001;
  localparam logic [4:0] OP_MULHU  = 5'b01010;
  localparam logic [4:0] OP_MULHSU = 5'b01011;
  localparam logic [4:0] OP_DIV    = 5'b01100;
  localparam logic [4:0] OP_DIVU   = 5'b01101;
  localparam logic [4:0] OP_REM    = 5'b01110;
  localparam logic [4:0] OP_REMU   = 5'b01111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Sign-fixup controls captured at acceptance, consumed in FIX
  typedef struct packed {
    logic is_rem;
    logic neg_q;
    logic neg_r;
  } fix_t;

  function automatic logic is_mul_op(input logic [4:0] op);
    return op[4:2] == 3'b010;
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return op[4:2] == 3'b011;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake bundle between the EX stage and the multiply/divide sequencer.
// master = EX stage issuing ops and consuming results; slave = sequencer.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start_valid;
  logic            start_ready;
  logic [4:0]      opcode;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            result_valid;
  logic            result_ready;
  logic [XLEN-1:0] result;

  modport master (
    output start_valid, opcode, operand_a, operand_b, result_ready,
    input  start_ready, result_valid, result
  );

  modport slave (
    input  start_valid, opcode, operand_a, operand_b, result_ready,
    output start_ready, result_valid, result
  );
endinterface

// File: rtl/div_iter_core.sv
// Unsigned restoring divider datapath: load magnitudes, then one quotient bit per step.
// No handshake; the sequencer owns step count and stall, results are valid after XLEN steps.
module div_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            fits;

  // Two guard bits: shifted partial remainder can exceed 2^XLEN
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = {1'b0, shifted} - {2'b00, dvs_q};
  assign fits    = ~diff[XLEN+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], fits};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M controller: pipelined multiply (MUL_LATENCY), iterative divide (XLEN+2), special cases in 1 cycle.
// One op in flight; result held in DONE until result_ready, start_ready only in IDLE; flush aborts.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave bus,
  input  logic    flush,
  output logic    busy
);

  localparam int CW       = $clog2(XLEN) + 1;
  localparam int MUL_LAST = (MUL_LATENCY > 2) ? MUL_LATENCY - 2 : 0;
  localparam int MCW      = (MUL_LAST > 0) ? $clog2(MUL_LAST + 1) : 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_nxt;
  logic            accept, div_load, div_step, mul_fin;
  logic [4:0]      op_q;
  logic [XLEN:0]   mul_a, mul_b;
  fix_t            fix_q;
  logic [CW-1:0]   counter;
  logic [MCW-1:0]  mul_cnt;
  logic [XLEN-1:0] result_q;

  logic [4:0]      in_op;
  logic [XLEN-1:0] in_a, in_b, abs_a, abs_b, special_res;
  logic            in_mul, in_div, in_sdiv, in_rem, div_zero, div_ovf, in_special;
  logic [XLEN:0]   ext_a, ext_b;

  assign in_op      = bus.opcode;
  assign in_a       = bus.operand_a;
  assign in_b       = bus.operand_b;
  assign in_mul     = is_mul_op(in_op);
  assign in_div     = is_div_op(in_op);
  assign in_sdiv    = in_div & ~in_op[0];
  assign in_rem     = in_op[1];
  assign div_zero   = (in_b == '0);
  assign div_ovf    = in_sdiv && (in_a == MIN_NEG) && (in_b == '1);
  assign in_special = in_div && (div_zero || div_ovf);

  // Covers divide-by-zero, signed overflow, and unsupported opcodes (left at zero)
  always_comb begin
    special_res = '0;
    if (in_div && div_zero)
      special_res = in_rem ? in_a : '1;
    else if (in_div && div_ovf)
      special_res = in_rem ? '0 : MIN_NEG;
  end

  assign ext_a = {in_a[XLEN-1] & ((in_op == OP_MULH) || (in_op == OP_MULHSU)), in_a};
  assign ext_b = {in_b[XLEN-1] & (in_op == OP_MULH), in_b};
  assign abs_a = (in_sdiv && in_a[XLEN-1]) ? -in_a : in_a;
  assign abs_b = (in_sdiv && in_b[XLEN-1]) ? -in_b : in_b;

  // Multiplier: 33x33 signed as 64-bit modular product of sign-extended operands
  logic [XLEN:0]     mx, my;
  logic [2*XLEN-1:0] product, prod_tail;
  logic [4:0]        mul_op;
  logic [XLEN-1:0]   mul_res;

  assign mx      = (state == IDLE) ? ext_a : mul_a;
  assign my      = (state == IDLE) ? ext_b : mul_b;
  assign product = {{(XLEN-1){mx[XLEN]}}, mx} * {{(XLEN-1){my[XLEN]}}, my};

  generate
    if (MUL_LATENCY > 2) begin : g_pipe
      logic [2*XLEN-1:0] pipe [MUL_LATENCY-2];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < MUL_LATENCY - 2; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= product;
          for (int i = 1; i < MUL_LATENCY - 2; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign prod_tail = pipe[MUL_LATENCY-3];
    end else begin : g_nopipe
      assign prod_tail = product;
    end
  endgenerate

  assign mul_op  = (state == IDLE) ? in_op : op_q;
  assign mul_res = (mul_op == OP_MUL) ? prod_tail[XLEN-1:0] : prod_tail[2*XLEN-1:XLEN];

  logic [XLEN-1:0] quo_mag, rem_mag, fix_q_val, fix_r_val, fix_res;

  div_iter_core #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .step      (div_step),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (quo_mag),
    .remainder (rem_mag)
  );

  assign fix_q_val = fix_q.neg_q ? -quo_mag : quo_mag;
  assign fix_r_val = fix_q.neg_r ? -rem_mag : rem_mag;
  assign fix_res   = fix_q.is_rem ? fix_r_val : fix_q_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    div_load  = 1'b0;
    div_step  = 1'b0;
    mul_fin   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_valid) begin
          accept = 1'b1;
          if (in_mul) begin
            if (MUL_LATENCY <= 1) begin
              state_nxt = DONE;
              mul_fin   = 1'b1;
            end else begin
              state_nxt = MUL;
            end
          end else if (in_div && !in_special) begin
            state_nxt = DIV;
            div_load  = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      MUL: begin
        if (mul_cnt == MCW'(MUL_LAST)) begin
          state_nxt = DONE;
          mul_fin   = 1'b1;
        end
      end
      DIV: begin
        div_step = (counter != '0);
        if (counter <= CW'(1)) state_nxt = FIX;
      end
      FIX:     state_nxt = DONE;
      DONE:    if (bus.result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      div_load  = 1'b0;
      div_step  = 1'b0;
      mul_fin   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      fix_q    <= '0;
      counter  <= '0;
      mul_cnt  <= '0;
      result_q <= '0;
    end else if (flush) begin
      counter <= '0;
      mul_cnt <= '0;
    end else begin
      if (accept) begin
        op_q         <= in_op;
        mul_a        <= ext_a;
        mul_b        <= ext_b;
        mul_cnt      <= '0;
        fix_q.is_rem <= in_rem;
        fix_q.neg_q  <= in_sdiv & (in_a[XLEN-1] ^ in_b[XLEN-1]);
        fix_q.neg_r  <= in_sdiv & in_a[XLEN-1];
        if (div_load) counter <= CW'(XLEN);
        if (state_nxt == DONE && !mul_fin) result_q <= special_res;
      end
      if (mul_fin)              result_q <= mul_res;
      else if (state == MUL)    mul_cnt  <= mul_cnt + 1'b1;
      if (div_step)             counter  <= counter - 1'b1;
      if (state == FIX)         result_q <= fix_res;
    end
  end

  assign bus.start_ready  = (state == IDLE);
  assign bus.result_valid = (state == DONE);
  assign bus.result       = result_q;
  assign busy             = (state != IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: results and latencies against hand-computed RV32M values,
// plus backpressure, flush and mid-op reset behaviour.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;
  int   tests = 0;
  int   fails = 0;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_sequencer #(.XLEN(32), .MUL_LATENCY(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .flush (flush),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure cycles from the acceptance edge (counted as 1) to result_valid.
  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                       input bit consume);
    int lat;
    @(negedge clk);
    check({tag, " start_ready"}, {31'b0, bus.start_ready}, 32'd1);
    bus.start_valid = 1'b1;
    bus.opcode      = op;
    bus.operand_a   = a;
    bus.operand_b   = b;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    bus.operand_a   = 32'hDEAD_BEEF;
    bus.operand_b   = 32'hDEAD_BEEF;
    lat = 1;
    while (!bus.result_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, bus.result, exp_res);
    if (consume) begin
      @(negedge clk);
      bus.result_ready = 1'b1;
      @(posedge clk); #1;
      bus.result_ready = 1'b0;
    end
  endtask

  initial begin
    bit seen;
    bus.start_valid  = 1'b0;
    bus.opcode       = '0;
    bus.operand_a    = '0;
    bus.operand_b    = '0;
    bus.result_ready = 1'b0;

    #3;
    check("reset start_ready", {31'b0, bus.start_ready}, 32'd1);
    check("reset result_valid", {31'b0, bus.result_valid}, 32'd0);
    check("reset result", bus.result, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("MUL",    OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 1'b1);
    do_op("MULHU",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 1'b1);
    do_op("MULH",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 1'b1);
    do_op("MULHSU", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b1);

    do_op("DIV",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b1);
    do_op("REM",  OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b1);
    do_op("DIVU", OP_DIVU, 32'd100,       32'd7, 32'd14,        34, 1'b1);
    do_op("REMU", OP_REMU, 32'd100,       32'd7, 32'd2,         34, 1'b1);

    do_op("DIVU by 0", OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 1'b1);
    do_op("REMU by 0", OP_REMU, 32'd5,         32'd0,         32'd5,         1, 1'b1);
    do_op("DIV ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
    do_op("REM ovf",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 1'b1);
    do_op("unsupported", 5'b00011, 32'd9, 32'd4, 32'd0, 1, 1'b1);

    // Backpressure: result and valid must hold while the consumer stalls
    do_op("MUL bp", OP_MUL, 32'd3, 32'd5, 32'd15, 2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp result_valid", {31'b0, bus.result_valid}, 32'd1);
      check("bp result", bus.result, 32'd15);
      check("bp start_ready", {31'b0, bus.start_ready}, 32'd0);
    end
    @(negedge clk);
    bus.result_ready = 1'b1;
    check("bp start_ready at handshake", {31'b0, bus.start_ready}, 32'd0);
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
    check("bp start_ready after", {31'b0, bus.start_ready}, 32'd1);
    check("bp result_valid after", {31'b0, bus.result_valid}, 32'd0);

    // Flush in the middle of a divide
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.opcode      = OP_DIVU;
    bus.operand_a   = 32'd1000;
    bus.operand_b   = 32'd3;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    check("flush busy in DIV", {31'b0, busy}, 32'd1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", {31'b0, busy}, 32'd0);
    check("flush start_ready", {31'b0, bus.start_ready}, 32'd1);
    check("flush result_valid", {31'b0, bus.result_valid}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.result_valid) seen = 1'b1;
    end
    check("flush no late result", {31'b0, seen}, 32'd0);

    // Flush coincident with a request: request is dropped
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.opcode      = OP_MUL;
    flush           = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    flush           = 1'b0;
    check("flush+start busy", {31'b0, busy}, 32'd0);
    check("flush+start start_ready", {31'b0, bus.start_ready}, 32'd1);

    // Asynchronous reset during MUL
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.opcode      = OP_MUL;
    bus.operand_a   = 32'd6;
    bus.operand_b   = 32'd7;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    check("pre-reset busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset start_ready", {31'b0, bus.start_ready}, 32'd1);
    check("mid reset result_valid", {31'b0, bus.result_valid}, 32'd0);
    check("mid reset result", bus.result, 32'd0);
    check("mid reset busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("DIVU after reset", OP_DIVU, 32'd9, 32'd3, 32'd3, 34, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
